// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM-stage
// data port (16-bit words/bytes) and a 128-bit line-oriented physical memory.
module dcache_wb #(
    parameter int IDX_BITS = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    input  logic         cnt_clear,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count,
    output logic [15:0]  wb_count
);
    localparam int LINES = 1 << IDX_BITS;
    localparam int TAG_W = 12 - IDX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL} state_e;

    state_e               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [TAG_W-1:0]     tag_d  [LINES];
    logic [127:0]         data_q [LINES];
    logic [127:0]         data_d [LINES];
    logic [IDX_BITS-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
    logic                 refilled_q, refilled_d;
    logic [15:0]          hit_count_q, hit_count_d;
    logic [15:0]          miss_count_q, miss_count_d;
    logic [15:0]          wb_count_q, wb_count_d;

    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [2:0]           word_sel;
    logic                 req;
    logic                 hit;
    logic [127:0]         cur_line;
    logic [127:0]         wr_line;
    logic                 hit_inc, miss_inc, wb_inc;

    assign req_idx  = mem_address[3+IDX_BITS:4];
    assign req_tag  = mem_address[15:4+IDX_BITS];
    assign word_sel = mem_address[3:1];
    assign req      = mem_read | mem_write;
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign cur_line = data_q[req_idx];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        miss_idx_d   = miss_idx_q;
        miss_tag_d   = miss_tag_q;
        refilled_d   = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        wb_inc       = 1'b0;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        wr_line      = cur_line;
        if (mem_byte_enable[0]) wr_line[{word_sel, 4'h0} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) wr_line[{word_sel, 4'h8} +: 8] = mem_wdata[15:8];

        case (state_q)
            S_IDLE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    // The replay that completes a miss is not a new hit.
                    hit_inc  = !refilled_q;
                    if (mem_write) begin
                        data_d[req_idx] = wr_line;
                        if (|mem_byte_enable) dirty_d[req_idx] = 1'b1;
                    end else begin
                        mem_rdata = cur_line[{word_sel, 4'h0} +: 16];
                    end
                end else if (req) begin
                    // Latch the miss so pmem_address holds even if the request drops.
                    miss_inc   = 1'b1;
                    miss_idx_d = req_idx;
                    miss_tag_d = req_tag;
                    state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_FILL;
                end
            end
            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[miss_idx_q], miss_idx_q, 4'h0};
                pmem_wdata   = data_q[miss_idx_q];
                if (pmem_resp) begin
                    wb_inc  = 1'b1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag_q, miss_idx_q, 4'h0};
                if (pmem_resp) begin
                    data_d[miss_idx_q]  = pmem_rdata;
                    tag_d[miss_idx_q]   = miss_tag_q;
                    valid_d[miss_idx_q] = 1'b1;
                    dirty_d[miss_idx_q] = 1'b0;
                    refilled_d          = 1'b1;
                    state_d             = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (cnt_clear) begin
            hit_count_d  = 16'h0000;
            miss_count_d = 16'h0000;
            wb_count_d   = 16'h0000;
        end else begin
            if (hit_inc)  hit_count_d  = sat_inc(hit_count_q);
            if (miss_inc) miss_count_d = sat_inc(miss_count_q);
            if (wb_inc)   wb_count_d   = sat_inc(wb_count_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
            refilled_q   <= 1'b0;
            hit_count_q  <= 16'h0000;
            miss_count_q <= 16'h0000;
            wb_count_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            miss_idx_q   <= miss_idx_d;
            miss_tag_q   <= miss_tag_d;
            refilled_q   <= refilled_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    // Line payload needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Randomized self-checking bench for dcache_wb: a line-level cache/memory model
// predicts every cycle's outputs; directed cases pin the model with literals.
module tb_dcache_wb;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address, mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic         cnt_clear;
    logic [15:0]  hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    dcache_wb #(.IDX_BITS(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .cnt_clear(cnt_clear), .hit_count(hit_count), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    int checks = 0;
    int failures = 0;

    // Model: resident line per index plus a sparse backing memory of lines.
    logic         m_valid [8];
    logic         m_dirty [8];
    logic [8:0]   m_tag   [8];
    logic [127:0] m_data  [8];
    logic [127:0] backing [logic [15:0]];

    logic         chk_en;
    logic         exp_resp, exp_rd_chk, exp_pr, exp_pw;
    logic [15:0]  exp_rdata, exp_paddr;
    logic [127:0] exp_pwdata;
    logic [15:0]  exp_hit, exp_miss, exp_wb;
    logic [15:0]  last_rdata, last_wb_addr, last_fill_addr;
    logic [127:0] last_wb_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic get_line(input logic [15:0] a, output logic [127:0] l);
        if (!backing.exists(a)) backing[a] = {$urandom, $urandom, $urandom, $urandom};
        l = backing[a];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hit = 16'h0; exp_miss = 16'h0; exp_wb = 16'h0;
        exp_resp = 1'b0; exp_rd_chk = 1'b0; exp_pr = 1'b0; exp_pw = 1'b0;
        exp_rdata = 16'h0; exp_paddr = 16'h0; exp_pwdata = 128'h0;
    endtask

    task automatic apply_write(input logic [2:0] idx, input logic [2:0] w,
                               input logic [15:0] wdata, input logic [1:0] be);
        if (be[0]) m_data[idx][w*16 +: 8] = wdata[7:0];
        if (be[1]) m_data[idx][w*16 + 8 +: 8] = wdata[15:8];
        if (be != 2'b00) m_dirty[idx] = 1'b1;
    endtask

    task automatic clear_counts();
        exp_hit = 16'h0; exp_miss = 16'h0; exp_wb = 16'h0;
    endtask

    // One complete access; drop_at >= 0 deasserts the request in that fill cycle.
    task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, input int wb_dly, input int fill_dly,
                          input int drop_at, input bit clr);
        logic [2:0]   idx;
        logic [8:0]   tg;
        logic [2:0]   w;
        logic [127:0] l;
        logic [15:0]  vaddr, faddr;
        bit           dropped;
        idx = addr[6:4]; tg = addr[15:7]; w = addr[3:1]; dropped = 1'b0;
        mem_read        = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        cnt_clear       = clr;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_resp = 1'b1; exp_rd_chk = !wr; exp_rdata = m_data[idx][w*16 +: 16];
            next_cycle();
            cnt_clear = 1'b0;
            if (clr) clear_counts(); else exp_hit = sat(exp_hit);
            if (wr) apply_write(idx, w, wdata, be);
        end else begin
            exp_resp = 1'b0;
            next_cycle();
            cnt_clear = 1'b0;
            if (clr) clear_counts(); else exp_miss = sat(exp_miss);
            if (m_valid[idx] && m_dirty[idx]) begin
                vaddr = {m_tag[idx], idx, 4'h0};
                exp_pw = 1'b1; exp_paddr = vaddr; exp_pwdata = m_data[idx];
                for (int k = 0; k <= wb_dly; k++) begin
                    pmem_resp  = (k == wb_dly);
                    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    next_cycle();
                end
                pmem_resp = 1'b0;
                backing[vaddr] = m_data[idx];
                exp_wb = sat(exp_wb);
                exp_pw = 1'b0;
            end
            faddr = {tg, idx, 4'h0};
            get_line(faddr, l);
            exp_pr = 1'b1; exp_paddr = faddr;
            for (int k = 0; k <= fill_dly; k++) begin
                if (k == drop_at) begin
                    mem_read = 1'b0; mem_write = 1'b0; dropped = 1'b1;
                end
                pmem_rdata = (k == fill_dly) ? l : {$urandom, $urandom, $urandom, $urandom};
                pmem_resp  = (k == fill_dly);
                next_cycle();
            end
            pmem_resp = 1'b0;
            exp_pr = 1'b0; exp_paddr = 16'h0;
            m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tg; m_data[idx] = l;
            if (!dropped) begin
                exp_resp = 1'b1; exp_rd_chk = !wr; exp_rdata = l[w*16 +: 16];
                next_cycle();
                if (wr) apply_write(idx, w, wdata, be);
            end
        end
        mem_read = 1'b0; mem_write = 1'b0; exp_resp = 1'b0;
        next_cycle();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_resp", 128'(mem_resp), 128'(exp_resp));
            if (exp_resp && exp_rd_chk) check("mem_rdata", 128'(mem_rdata), 128'(exp_rdata));
            check("pmem_read", 128'(pmem_read), 128'(exp_pr));
            check("pmem_write", 128'(pmem_write), 128'(exp_pw));
            check("pmem_address", 128'(pmem_address), (exp_pr || exp_pw) ? 128'(exp_paddr) : 128'h0);
            if (exp_pw) check("pmem_wdata", pmem_wdata, exp_pwdata);
            check("hit_count", 128'(hit_count), 128'(exp_hit));
            check("miss_count", 128'(miss_count), 128'(exp_miss));
            check("wb_count", 128'(wb_count), 128'(exp_wb));
            if (mem_resp && mem_read && !mem_write) last_rdata = mem_rdata;
            if (pmem_write) begin
                last_wb_addr = pmem_address;
                last_wb_data = pmem_wdata;
            end
            if (pmem_read) last_fill_addr = pmem_address;
        end
    end

    initial begin
        logic [127:0] l;
        logic [15:0]  a;
        int           fd;
        chk_en = 1'b0;
        reset_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0; mem_wdata = 16'h0;
        mem_byte_enable = 2'b00; pmem_rdata = 128'h0; pmem_resp = 1'b0; cnt_clear = 1'b0;
        last_rdata = 16'h0; last_wb_addr = 16'h0; last_fill_addr = 16'h0; last_wb_data = 128'h0;
        model_reset();

        #2;
        check("rst_mem_resp", 128'(mem_resp), 128'h0);
        check("rst_pmem_rw", 128'({pmem_read, pmem_write}), 128'h0);
        check("rst_pmem_address", 128'(pmem_address), 128'h0);
        check("rst_mem_rdata", 128'(mem_rdata), 128'h0);
        check("rst_counts", 128'({hit_count, miss_count, wb_count}), 128'h0);
        next_cycle();
        reset_n = 1'b1;
        chk_en = 1'b1;
        next_cycle();

        l = {$urandom, $urandom, $urandom, $urandom};
        l[31:16] = 16'hBEEF;
        l[47:32] = 16'h1234;
        backing[16'h0100] = l;

        access(0, 16'h0102, 16'h0, 2'b11, 0, 0, -1, 0);
        check("cold_rdata", 128'(last_rdata), 128'hBEEF);
        check("cold_fill_addr", 128'(last_fill_addr), 128'h0100);
        check("cold_counts", 128'({hit_count, miss_count}), 128'h0000_0001);
        access(0, 16'h0102, 16'h0, 2'b11, 0, 0, -1, 0);
        check("hit_rdata", 128'(last_rdata), 128'hBEEF);
        check("hit_count1", 128'(hit_count), 128'd1);
        access(0, 16'h0104, 16'h0, 2'b11, 0, 0, -1, 0);
        check("word2_rdata", 128'(last_rdata), 128'h1234);
        check("hit_count2", 128'(hit_count), 128'd2);
        access(1, 16'h0103, 16'h5A00, 2'b10, 0, 0, -1, 0);
        access(0, 16'h0102, 16'h0, 2'b11, 0, 0, -1, 0);
        check("byte_write_rdata", 128'(last_rdata), 128'h5AEF);
        access(0, 16'h0902, 16'h0, 2'b11, 2, 1, -1, 0);
        check("wb_addr", 128'(last_wb_addr), 128'h0100);
        check("wb_word1", 128'(last_wb_data[31:16]), 128'h5AEF);
        check("wb_count1", 128'(wb_count), 128'd1);
        check("conflict_fill_addr", 128'(last_fill_addr), 128'h0900);
        access(0, 16'h1102, 16'h0, 2'b11, 0, 5, -1, 0);
        access(0, 16'h0102, 16'h0, 2'b11, 0, 4, 2, 0);
        access(0, 16'h0102, 16'h0, 2'b11, 0, 0, -1, 0);
        access(1, 16'h0104, 16'hFFFF, 2'b00, 0, 0, -1, 0);
        access(0, 16'h0902, 16'h0, 2'b11, 0, 0, -1, 0);
        check("dropped_counts", 128'({hit_count, miss_count, wb_count}), 128'h0006_0005_0001);

        for (int n = 0; n < 200; n++) begin
            a  = {7'($urandom_range(0, 3)), 9'($urandom_range(0, 511))};
            fd = $urandom_range(0, 3);
            access(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3), fd,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, fd)) : -1,
                   ($urandom_range(0, 24) == 0));
        end

        force dut.miss_count_q = 16'hFFFF;
        #1;
        release dut.miss_count_q;
        exp_miss = 16'hFFFF;
        access(0, 16'hFF82, 16'h0, 2'b11, 0, 1, -1, 0);
        check("miss_saturated", 128'(miss_count), 128'hFFFF);
        access(0, 16'hFF92, 16'h0, 2'b11, 0, 1, -1, 1);
        check("clear_over_miss", 128'({hit_count, miss_count, wb_count}), 128'h0);

        access(1, 16'hFFA2, 16'h7777, 2'b11, 0, 0, -1, 0);
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h0122;
        exp_resp = 1'b0;
        next_cycle();
        exp_miss = sat(exp_miss);
        exp_pw = 1'b1; exp_paddr = 16'hFFA0; exp_pwdata = m_data[2];
        @(negedge clk);
        #1;
        check("wb_before_reset", 128'(pmem_write), 128'h1);
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("reset_drops_pmem", 128'({pmem_read, pmem_write}), 128'h0);
        check("reset_counts", 128'(miss_count), 128'h0);
        mem_read = 1'b0;
        model_reset();
        next_cycle();
        reset_n = 1'b1;
        chk_en = 1'b1;
        next_cycle();
        access(0, 16'h0102, 16'h0, 2'b11, 0, 0, -1, 0);
        check("post_reset_miss", 128'({hit_count, miss_count}), 128'h0000_0001);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits directly downstream of the pipeline's data-memory port (d_mem_*) and upstream of the physical memory line interface (pmem_*).
- Serves 16-bit word and byte accesses from the MEM stage and moves full 128-bit lines to and from physical memory.
- Exports saturating hit, miss and writeback counters for the performance-counter mux.

Parameters:
- IDX_BITS, 3, log2 of the number of lines. Default is 8 lines of 16 bytes. Tag width = 12 - IDX_BITS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mem_read  in  1  pipeline read request; held until mem_resp
- mem_write  in  1  pipeline write request; held until mem_resp
- mem_address  in  16  byte address
- mem_wdata  in  16  write data
- mem_byte_enable  in  2  bit0 = low byte, bit1 = high byte
- mem_rdata  out  16  read data, valid while mem_resp=1
- mem_resp  out  1  request complete
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_address  out  16  line-aligned address, [3:0]=0
- pmem_wdata  out  128  writeback line
- pmem_rdata  in  128  fill line
- pmem_resp  in  1  physical memory transfer complete
- cnt_clear  in  1  synchronous clear of all counters
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter
- wb_count  out  16  saturating writeback counter

Behaviour:
- Address split: offset = addr[3:0] (word select = addr[3:1]); index = addr[3+IDX_BITS:4]; tag = addr[15:4+IDX_BITS].
- Storage is flop-based, per line: valid, dirty, tag, 128-bit data.
- Reset (async, reset_n=0):
  - All valid and dirty bits = 0.
  - State = IDLE.
  - Counters = 0.
  - mem_resp = pmem_read = pmem_write = 0.
  - mem_rdata = 0, pmem_address = 0.
- Simultaneous mem_read and mem_write is treated as a write.
- State IDLE, request present:
  - Hit (valid && tag match): mem_resp=1 combinationally in the same cycle.
    - Read: mem_rdata = selected word.
    - Write: bytes selected by mem_byte_enable are written at the next edge; dirty is set. Byte enable 00 still responds but leaves the line unchanged and dirty not set.
  - Miss, line clean: go to FILL next cycle; miss_count += 1.
  - Miss, line dirty: go to WRITEBACK next cycle; miss_count += 1.
  - No request: stay in IDLE, all outputs 0.
- State WRITEBACK:
  - pmem_write=1, pmem_address = {stored tag, index, 4'h0}, pmem_wdata = stored line.
  - Stay until pmem_resp=1.
  - On pmem_resp: wb_count += 1, go to FILL.
- State FILL:
  - pmem_read=1, pmem_address = {req tag, index, 4'h0}.
  - Stay until pmem_resp=1.
  - On pmem_resp: line data = pmem_rdata, tag = req tag, valid=1, dirty=0. Go to IDLE.
- Miss replay: the held request now hits in IDLE and completes. This replay hit does not increment hit_count (a one-cycle "refilled" flag suppresses it).
- mem_resp is never asserted in WRITEBACK or FILL.
- Total miss latency: 1 (IDLE detect) + writeback cycles (if dirty) + fill cycles + 1 (replay).
- Request dropped mid-miss: the pmem transfer in progress completes. The line is installed, then the cache returns to IDLE with no mem_resp.
- pmem_read and pmem_write are never both 1.
- pmem_address is constant while a pmem request is held.
- Counters:
  - 16-bit, saturating at 16'hFFFF.
  - cnt_clear has priority over increment in the same cycle.
  - Counters are unaffected by state except as listed above.
- reset_n asserted mid-miss aborts immediately: pmem_* drop to 0 asynchronously and all lines are invalidated.

Test Plan:
- Cold read at 0x0102: miss_count=1; FILL with pmem_address=0x0100; pmem_rdata word1=0xBEEF; then mem_resp with mem_rdata=0xBEEF; hit_count=0.
- Repeat read at 0x0102 -> mem_resp in the same cycle, mem_rdata=0xBEEF, hit_count=1. Next, read 0x0104 after the line is filled with word2=0x1234 -> 0x1234, hit_count=2.
- Byte write 0x0103 with byte_enable=10, wdata=0x5A00 -> next read of 0x0102 returns 0x5AEF; line is dirty.
- Dirty conflict: read 0x0902 (same index, tag differs; IDX_BITS=3):
  - WRITEBACK with pmem_address=0x0100 and pmem_wdata containing 0x5AEF, then wb_count=1.
  - FILL with pmem_address=0x0900, then mem_resp.
- Delay pmem_resp 5 cycles in FILL -> pmem_read held with constant address, mem_resp=0 throughout. Deassert mem_read mid-fill -> line still installed, no mem_resp.
- Force miss_count to 0xFFFF, then miss again -> stays 0xFFFF. cnt_clear together with a miss -> 0. reset_n low during WRITEBACK -> pmem_write=0 immediately, subsequent read of 0x0102 misses.
